mem_port_arbiter: RTL

Shares the single-port data/instruction memory between the CPU control path and a DMA/loader requester. Selects one access per cycle with CPU priority, bounded starvation for DMA, and an optional locked DMA burst. Stalls the loser and routes registered read-valid back to the issuing requester. Sits between the CPU, the DMA engine and the RAM; the RAM is synchronous, with read data one cycle after the command.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/sat_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and types for the memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b10;
    localparam logic [1:0] MEM_WRITE = 2'b01;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CPU,
        ARB_DMA,
        ARB_DMA_LOCK
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

    // 11 is illegal on the CPU side and behaves like no request.
    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == MEM_READ) || (cmd == MEM_WRITE);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins) and async reset.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between CPU and DMA: CPU priority, bounded DMA
// starvation, optional locked DMA bursts, and read-valid routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 16,
    parameter int MAX_CPU_RUN   = 4,
    parameter int MAX_DMA_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cpu_cmd,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int RUN_W   = $clog2(MAX_CPU_RUN + 1);
    localparam int BURST_W = $clog2(MAX_DMA_BURST + 1);

    arb_state_t         state;
    arb_state_t         next_state;
    logic               cpu_pending;
    logic               grant_cpu;
    logic               grant_dma;
    logic [RUN_W-1:0]   cpu_run;
    logic               run_at_max;
    logic [BURST_W-1:0] burst_cnt;
    logic               burst_at_max;
    logic               rd_valid_q;
    owner_t             rd_owner_q;

    assign cpu_pending = is_access(cpu_cmd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // burst_cnt saturates at MAX_DMA_BURST, so !burst_at_max means below the limit.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        next_state = ARB_IDLE;
        mem_cmd    = MEM_NONE;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (state == ARB_DMA_LOCK && dma_req && !burst_at_max) begin
            grant_dma = 1'b1;
        end else if (cpu_pending && dma_req) begin
            if (run_at_max) begin
                grant_dma = 1'b1;
            end else begin
                grant_cpu = 1'b1;
            end
        end else if (cpu_pending) begin
            grant_cpu = 1'b1;
        end else if (dma_req) begin
            grant_dma = 1'b1;
        end

        if (grant_cpu) begin
            mem_cmd    = cpu_cmd;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            next_state = ARB_CPU;
        end else if (grant_dma) begin
            mem_cmd    = dma_we ? MEM_WRITE : MEM_READ;
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            next_state = dma_lock ? ARB_DMA_LOCK : ARB_DMA;
        end
    end

    assign cpu_stall = cpu_pending && !grant_cpu;
    assign dma_ack   = grant_dma;

    sat_counter #(.W(RUN_W), .MAX(MAX_CPU_RUN)) u_cpu_run (
        .clk    (clk),
        .reset  (reset),
        .inc    (grant_cpu && dma_req),
        .clr    (grant_dma || !dma_req),
        .count  (cpu_run),
        .at_max (run_at_max)
    );

    // Anything other than a locked DMA grant ends (or never starts) a burst.
    sat_counter #(.W(BURST_W), .MAX(MAX_DMA_BURST)) u_burst_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (grant_dma && dma_lock),
        .clr    (!(grant_dma && dma_lock)),
        .count  (burst_cnt),
        .at_max (burst_at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            rd_valid_q <= (mem_cmd == MEM_READ);
            rd_owner_q <= grant_dma ? OWN_DMA : OWN_CPU;
        end
    end

    assign cpu_rvalid = rd_valid_q && (rd_owner_q == OWN_CPU);
    assign dma_rvalid = rd_valid_q && (rd_owner_q == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule
